// File: rtl/iterative_caesar_cipher_engine.sv
//==============================================================================
// iterative_caesar_cipher_engine : one-round-per-clock invertible XOR/add/shift
// block cipher with encrypt/decrypt mode and valid/ready streams.  Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module iterative_caesar_cipher_engine #(
  parameter int DATA_W = 8,
  parameter int ROUNDS = 3,
  parameter int SHIFT  = DATA_W / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(ROUNDS - 1);

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] key_q,       key_d;
  logic [DATA_W-1:0] blk_key_q,   blk_key_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              mode_q,      mode_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                             input logic [CNT_W-1:0]  amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {v, v} << (int'(amt) % DATA_W);
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

  logic [CNT_W-1:0]  round_idx;
  logic [DATA_W-1:0] round_key;
  logic [DATA_W-1:0] enc_a, enc_b, enc_y;
  logic [DATA_W-1:0] dec_b, dec_a, dec_x;
  logic [DATA_W-1:0] round_out;

  // Decrypt walks the round keys backwards so each step undoes the matching encrypt round.
  assign round_idx = mode_q ? (C_LAST_CNT - cnt_q) : cnt_q;
  assign round_key = rotl(blk_key_q, round_idx);

  assign enc_a = data_q ^ round_key;
  assign enc_b = enc_a + round_key;
  assign enc_y = enc_b ^ (enc_b >> SHIFT);

  // One xor-shift pass inverts the diffusion step since SHIFT covers at least half the word.
  assign dec_b = data_q ^ (data_q >> SHIFT);
  assign dec_a = dec_b - round_key;
  assign dec_x = dec_a ^ round_key;

  assign round_out = mode_q ? dec_x : enc_y;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    blk_key_d   = blk_key_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_load) begin
          key_d = key_in;
        end
        // The block latches the pre-edge key, so a simultaneous key_load only affects later blocks.
        if (in_valid) begin
          mode_d    = in_mode;
          blk_key_d = key_q;
          data_d    = in_mode ? (in_data ^ key_q) : in_data;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        data_d = round_out;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_CNT) begin
          out_data_d  = mode_q ? round_out : (round_out ^ blk_key_q);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      blk_key_q   <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      blk_key_q   <= blk_key_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_caesar_cipher_engine.sv
//==============================================================================
// tb_iterative_caesar_cipher_engine : scoreboard bench for the cipher engine,
// directed tests on an 8-bit/3-round instance plus multi-config sweeps. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iterative_caesar_cipher_engine;

  localparam int W = 8;
  localparam int R = 3;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     = 1'b0;
  logic [W-1:0] key_in    = '0;
  logic         key_load  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_mode   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int acc_cyc     = 0;
  int sweeps_done = 0;
  logic [W-1:0] tb_key = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  iterative_caesar_cipher_engine #(.DATA_W(W), .ROUNDS(R)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark_done();
    sweeps_done++;
  endtask

  // Reference cipher written straight from the round equations, generic in width.
  function automatic logic [31:0] model_enc(input logic [31:0] p, input logic [31:0] k,
                                            input int w, input int rounds, input int sh);
    logic [31:0] mask, x, kr, a, b;
    int amt;
    mask = (32'd1 << w) - 32'd1;
    x = p & mask;
    for (int r = 0; r < rounds; r++) begin
      amt = r % w;
      kr  = (amt == 0) ? (k & mask) : (((k << amt) | ((k & mask) >> (w - amt))) & mask);
      a   = x ^ kr;
      b   = (a + kr) & mask;
      x   = b ^ (b >> sh);
    end
    return (x ^ k) & mask;
  endfunction

  task automatic load_key(input logic [W-1:0] k);
    key_in = k; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    tb_key = k;
  endtask

  task automatic accept(input logic [W-1:0] d, input logic m);
    int n = 0;
    in_data = d; in_mode = m; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold, output logic [W-1:0] res);
    int n = 0;
    logic [W-1:0] held;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(R));
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
    held = out_data;
    res  = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      check({tag, "_hold_vld"},  32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"},  32'(in_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_in_rdy"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] c;
    logic seen;
    int n;

    repeat (2) @(negedge clk);
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy",  32'(in_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-derived known answer: key 0x01, plaintext 0x00, three rounds.
    load_key(8'h01);
    exp_q.push_back(8'h0B);
    accept(8'h00, 1'b0);
    collect("enc_k01", 0, c);

    load_key(8'h5A);
    exp_q.push_back(W'(model_enc(32'h3C, 32'(tb_key), W, R, W/2)));
    accept(8'h3C, 1'b0);
    collect("rt_enc", 0, c);
    exp_q.push_back(8'h3C);
    accept(c, 1'b1);
    collect("rt_dec", 0, c);

    exp_q.push_back(W'(model_enc(32'hA5, 32'(tb_key), W, R, W/2)));
    accept(8'hA5, 1'b0);
    collect("bp", 10, c);

    exp_q.push_back(W'(model_enc(32'h11, 32'(tb_key), W, R, W/2)));
    accept(8'h11, 1'b0);
    key_in = 8'hFF; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    collect("kl_run", 0, c);
    exp_q.push_back(W'(model_enc(32'h11, 32'(tb_key), W, R, W/2)));
    accept(8'h11, 1'b0);
    collect("kl_run_after", 0, c);

    exp_q.push_back(W'(model_enc(32'h22, 32'(tb_key), W, R, W/2)));
    key_in = 8'h33; key_load = 1'b1;
    accept(8'h22, 1'b0);
    key_load = 1'b0;
    tb_key = 8'h33;
    collect("kl_acc_old", 0, c);
    exp_q.push_back(W'(model_enc(32'h22, 32'(tb_key), W, R, W/2)));
    accept(8'h22, 1'b0);
    collect("kl_acc_new", 0, c);

    accept(8'h77, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_vld",  32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy",  32'(in_ready), 32'd1);
    check("mid_rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tb_key = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("mid_rst_no_out", 32'(seen), 32'd0);
    check("mid_rst_idle",   32'(in_ready), 32'd1);
    exp_q.push_back(W'(model_enc(32'h5A, 32'(tb_key), W, R, W/2)));
    accept(8'h5A, 1'b0);
    collect("post_rst", 0, c);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    n = 0;
    while (sweeps_done < 4 && n < 40000) begin @(negedge clk); n++; end
    check("sweeps_complete", 32'(sweeps_done), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW  = (g < 2) ? 8 : 16;
    localparam int SR  = (g == 0) ? 1 : (g == 1) ? 5 : (g == 2) ? 3 : 5;
    localparam int SSH = (g == 3) ? 12 : SW / 2;

    logic          s_rst_n = 1'b0;
    logic [SW-1:0] s_key   = '0;
    logic          s_kl    = 1'b0;
    logic [SW-1:0] s_din   = '0;
    logic          s_mode  = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ordy  = 1'b0;
    logic          s_irdy;
    logic [SW-1:0] s_dout;
    logic          s_ovld;
    logic          s_busy;
    logic [SW-1:0] s_exp_q[$];

    iterative_caesar_cipher_engine #(.DATA_W(SW), .ROUNDS(SR), .SHIFT(SSH)) u_dut (
      .clk(clk), .rst_n(s_rst_n), .key_in(s_key), .key_load(s_kl),
      .in_data(s_din), .in_mode(s_mode), .in_valid(s_valid), .in_ready(s_irdy),
      .out_data(s_dout), .out_valid(s_ovld), .out_ready(s_ordy), .busy(s_busy)
    );

    task automatic run_block(input logic [SW-1:0] d, input logic m, input string tag);
      int n = 0;
      int t0;
      s_din = d; s_mode = m; s_valid = 1'b1;
      while (!s_irdy && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      t0 = cyc; s_valid = 1'b0; n = 0;
      while (!s_ovld && n < 100) begin @(negedge clk); n++; end
      check($sformatf("cfg%0d_%s_lat", g, tag), 32'(cyc - t0), 32'(SR));
      if (s_exp_q.size() == 0) check($sformatf("cfg%0d_%s_sb_empty", g, tag), 32'd0, 32'd1);
      else check($sformatf("cfg%0d_%s_data", g, tag), 32'(s_dout), 32'(s_exp_q.pop_front()));
      s_ordy = 1'b1;
      @(negedge clk);
      s_ordy = 1'b0;
    endtask

    initial begin
      logic [SW-1:0] k, p, c;
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 250; i++) begin
        k = (i == 0) ? SW'(8'h5A) : SW'($urandom());
        p = (i == 0) ? SW'(8'h3C) : SW'($urandom());
        s_key = k; s_kl = 1'b1;
        @(negedge clk);
        s_kl = 1'b0;
        // Known answer for the single-round 8-bit build; model elsewhere.
        c = (SW == 8 && SR == 1 && i == 0) ? SW'(8'h96)
                                           : SW'(model_enc(32'(p), 32'(k), SW, SR, SSH));
        s_exp_q.push_back(c);
        run_block(p, 1'b0, "enc");
        s_exp_q.push_back(p);
        run_block(c, 1'b1, "dec");
      end
      mark_done();
    end
  end

endmodule

`default_nettype wire
